// File: rtl/controlador_lcd.sv
// HD44780 write-side bus driver: one 9-bit word per Listo/Dato_Valido handshake, timed E strobe, cycle-counted execution wait.
// Optional build macro INIT_SEQ_EN adds the autonomous power-on 0x30/0x30/0x30/0x38 sequence.
module controlador_lcd #(
  parameter int unsigned T_SETUP      = 4,
  parameter int unsigned T_PULSE      = 12,
  parameter int unsigned T_HOLD       = 2,
  parameter int unsigned T_EXEC       = 2000,
  parameter int unsigned T_EXEC_LARGO = 82000,
  parameter int unsigned T_INIT       = 750000,
  parameter int unsigned T_INIT2      = 205000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [8:0] Datos_LCD,
  input  logic       Dato_Valido,
  output logic       Listo,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB
);

  localparam longint unsigned CNT_LIM = 64'(1) << CNT_W;

  // Waits that end in REPOSO are one cycle short: the Listo cycle itself completes the execution time.
  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] C_PULSO = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] C_EXEC  = CNT_W'(T_EXEC - 2);
  localparam logic [CNT_W-1:0] C_LARGO = CNT_W'(T_EXEC_LARGO - 2);

  if (T_SETUP == 0 || T_PULSE == 0 || T_HOLD == 0 || T_EXEC < 2 || T_EXEC_LARGO < 2 ||
      T_INIT == 0 || T_INIT2 < 2 ||
      64'(T_SETUP) > CNT_LIM || 64'(T_PULSE) > CNT_LIM || 64'(T_HOLD) > CNT_LIM ||
      64'(T_EXEC) > CNT_LIM || 64'(T_EXEC_LARGO) > CNT_LIM ||
      64'(T_INIT) > CNT_LIM || 64'(T_INIT2) > CNT_LIM) begin : g_param_err
    $error("controlador_lcd: timing parameter out of range for CNT_W");
  end

  typedef enum logic [2:0] {
    S_REPOSO,
    S_SETUP,
    S_PULSO,
    S_HOLD,
    S_ESPERA,
    S_INIT
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             largo_q, largo_d;
  logic             rs_d;
  logic [7:0]       db_d;
  logic             e_d;
  logic             listo_d;

`ifdef INIT_SEQ_EN
  localparam logic [CNT_W-1:0] C_INIT         = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0] C_INIT2_CADENA = CNT_W'(T_INIT2 - 1);
  localparam logic [CNT_W-1:0] C_EXEC_CADENA  = CNT_W'(T_EXEC - 1);

  logic       cadena_q, cadena_d;
  logic [1:0] idx_q, idx_d;
`endif

  assign LCD_RW = 1'b0;

  // Next-state, counter and next-output logic.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    largo_d  = largo_q;
    rs_d     = LCD_RS;
    db_d     = LCD_DB;
`ifdef INIT_SEQ_EN
    cadena_d = cadena_q;
    idx_d    = idx_q;
`endif

    case (estado_q)
      S_REPOSO: begin
        if (Listo && Dato_Valido) begin
          estado_d = S_SETUP;
          cnt_d    = C_SETUP;
          rs_d     = Datos_LCD[8];
          db_d     = Datos_LCD[7:0];
          largo_d  = !Datos_LCD[8] && (Datos_LCD[7:2] == 6'd0) && (Datos_LCD[1:0] != 2'd0);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          estado_d = S_PULSO;
          cnt_d    = C_PULSO;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PULSO: begin
        if (cnt_q == '0) begin
          estado_d = S_HOLD;
          cnt_d    = C_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          estado_d = S_ESPERA;
          cnt_d    = largo_q ? C_LARGO : C_EXEC;
`ifdef INIT_SEQ_EN
          // Chained init writes wait a full period so the next word lands one period after the last.
          if (cadena_q && idx_q == 2'd0) begin
            cnt_d = C_INIT2_CADENA;
          end else if (cadena_q && idx_q != 2'd3) begin
            cnt_d = C_EXEC_CADENA;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ESPERA: begin
        if (cnt_q == '0) begin
          estado_d = S_REPOSO;
`ifdef INIT_SEQ_EN
          if (cadena_q && idx_q != 2'd3) begin
            estado_d = S_SETUP;
            cnt_d    = C_SETUP;
            idx_d    = idx_q + 2'd1;
            db_d     = (idx_q == 2'd2) ? 8'h38 : 8'h30;
          end else begin
            cadena_d = 1'b0;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef INIT_SEQ_EN
      S_INIT: begin
        if (cnt_q == '0) begin
          estado_d = S_SETUP;
          cnt_d    = C_SETUP;
          rs_d     = 1'b0;
          db_d     = 8'h30;
          largo_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: begin
        estado_d = S_REPOSO;
        cnt_d    = '0;
      end
    endcase

    e_d     = (estado_d == S_PULSO);
    listo_d = (estado_d == S_REPOSO);
  end

  // State, counter and output registers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
`ifdef INIT_SEQ_EN
      estado_q <= S_INIT;
      cnt_q    <= C_INIT;
      cadena_q <= 1'b1;
      idx_q    <= 2'd0;
      Listo    <= 1'b0;
`else
      estado_q <= S_REPOSO;
      cnt_q    <= '0;
      Listo    <= 1'b1;
`endif
      largo_q  <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DB   <= 8'h00;
      LCD_E    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      largo_q  <= largo_d;
      LCD_RS   <= rs_d;
      LCD_DB   <= db_d;
      LCD_E    <= e_d;
      Listo    <= listo_d;
`ifdef INIT_SEQ_EN
      cadena_q <= cadena_d;
      idx_q    <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_controlador_lcd.sv
// Self-checking bench for controlador_lcd (default build): directed steps plus random traffic
// checked every cycle against a timeline model of the write protocol.
module tb_controlador_lcd;

  localparam int TS = 2;
  localparam int TP = 3;
  localparam int TH = 1;
  localparam int TE = 10;
  localparam int TL = 40;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [8:0] Datos_LCD;
  logic       Dato_Valido;
  logic       Listo;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic [7:0] LCD_DB;

  controlador_lcd #(
    .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .T_EXEC_LARGO(TL),
    .T_INIT(50), .T_INIT2(20), .CNT_W(8)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .Datos_LCD(Datos_LCD), .Dato_Valido(Dato_Valido),
    .Listo(Listo), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_DB(LCD_DB)
  );

  initial forever #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a transaction is (acceptance cycle, word, total period W).
  bit         m_busy   = 0;
  bit         m_listo  = 0;
  bit         m_e      = 0;
  bit         m_acc_ok = 0;
  int         m_acc    = 0;
  int         m_w      = 0;
  logic       m_rs     = 1'b0;
  logic [7:0] m_db     = 8'h00;

  int   rise_q[$];
  int   fall_q[$];
  logic e_prev = 1'b0;

  function automatic bit is_long(input logic [8:0] w);
    return (w[8] == 1'b0) && (w[7:0] == 8'h01 || w[7:0] == 8'h02 || w[7:0] == 8'h03);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic tick(input logic r, input logic v, input logic [8:0] w);
    RESET = r; Dato_Valido = v; Datos_LCD = w;
    @(posedge CLOCK);
    cyc++;
    m_acc_ok = 0;
    if (r) begin
      m_busy = 0; m_rs = 1'b0; m_db = 8'h00;
    end else if (m_listo && v) begin
      m_busy = 1; m_acc = cyc; m_rs = w[8]; m_db = w[7:0];
      m_w = TS + TP + TH + (is_long(w) ? TL : TE);
      m_acc_ok = 1;
    end
    m_e = m_busy && (cyc - m_acc) >= TS && (cyc - m_acc) < TS + TP;
    // Listo must be sampled high at edge A+W, so it is visible from just after edge A+W-1.
    if (m_busy && (cyc - m_acc) >= m_w - 1) m_busy = 0;
    m_listo = !m_busy;
    #1;
    if (LCD_E === 1'b1 && e_prev !== 1'b1) rise_q.push_back(cyc);
    if (LCD_E === 1'b0 && e_prev === 1'b1) fall_q.push_back(cyc);
    e_prev = LCD_E;
    chk("lcd_e", 32'(LCD_E), 32'(m_e));
    chk("listo", 32'(Listo), 32'(m_listo));
    chk("lcd_rs", 32'(LCD_RS), 32'(m_rs));
    chk("lcd_db", 32'(LCD_DB), 32'(m_db));
    chk("lcd_rw", 32'(LCD_RW), 32'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 9'($urandom));
  endtask

  // Hold a word with Dato_Valido until the model accepts it; bounded wait.
  task automatic send(input logic [8:0] w, output int acc);
    int n;
    n = 0;
    acc = -1;
    do begin
      tick(1'b0, 1'b1, w);
      n++;
    end while (!m_acc_ok && n < 100);
    total++;
    assert (m_acc_ok) else begin
      bad++;
      $error("FAIL send_timeout word=%0h waited=%0d limit=%0d", w, n, 100);
    end
    acc = cyc;
  endtask

  initial begin
    int a, a2, nr;
    logic [8:0] wtab [5];
    wtab[0] = 9'h000; wtab[1] = 9'h003; wtab[2] = 9'h004; wtab[3] = 9'h101; wtab[4] = 9'h002;

    // Reset, including reset together with a valid word.
    tick(1'b1, 1'b0, 9'h000);
    tick(1'b1, 1'b1, 9'h1FF);
    idle(2);

    // Data write timing.
    send(9'h141, a);
    idle(20);
    chk("data_rise", 32'(rise_q[$]), 32'(a + TS));
    chk("data_fall", 32'(fall_q[$]), 32'(a + TS + TP));

    // Clear command (long wait) and a normal command.
    send(9'h001, a);
    idle(50);
    send(9'h038, a);
    idle(20);

    // Back-to-back with Dato_Valido held high.
    nr = rise_q.size();
    send(9'h148, a);
    send(9'h14C, a2);
    idle(20);
    chk("b2b_accept_gap", 32'(a2 - a), 32'(TS + TP + TH + TE));
    chk("b2b_pulses", 32'(rise_q.size() - nr), 32'(2));
    chk("b2b_rise_gap", 32'(rise_q[$] - rise_q[$-1]), 32'(TS + TP + TH + TE));

    // Ignored input while busy: valid toggled with other words.
    send(9'h155, a);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'($urandom_range(0, 1)), 9'($urandom));
    idle(10);

    // Boundary words around the long-wait set.
    foreach (wtab[k]) begin
      send(wtab[k], a);
      idle(TS + TP + TH + TL + 2);
    end

    // Reset while E is high.
    send(9'h17A, a);
    idle(2);
    tick(1'b1, 1'b0, 9'h000);
    nr = rise_q.size();
    idle(25);
    chk("no_pulse_after_reset", 32'(rise_q.size()), 32'(nr));

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      logic r, v;
      logic [8:0] w;
      r = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 2) != 0);
      w[8] = 1'($urandom_range(0, 1));
      w[7:0] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      tick(r, v, w);
    end
    idle(TS + TP + TH + TL + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
